adder_share_ctrl: RTL and testbench
===================================

Name: adder_share_ctrl

Overview:
- Two-requester controller that shares one rca_32 slice to perform 64-bit add/subtract over two cycles: low half first, then high half.
- Round-robin arbitration between the requesters; valid/ready handshakes on the request and response sides.
- Area-reduced alternative to a full-width rca_64 for non-timing-critical ALU paths.

Parameters:
- W, 64, operand width; fixed at 2*32 (one rca_32 slice reused per half).
- HALF, 32, slice width; W/2.

Ports:
- clk  input  1  clock; all state updates on the rising edge.
- rst  input  1  synchronous, active-high reset.
- req0_valid  input  1  requester 0 has an operation.
- req0_ready  output  1  requester 0 accepted this cycle.
- req0_a  input  64  operand A, requester 0.
- req0_b  input  64  operand B, requester 0.
- req0_sub  input  1  1 = A-B, 0 = A+B.
- req1_valid, req1_ready, req1_a, req1_b, req1_sub: same as requester 0, for requester 1.
- resp_valid  output  1  result available.
- resp_ready  input  1  consumer accepts the result.
- resp_sum  output  64  result.
- resp_cout  output  1  carry out of bit 63 (for subtract: 1 = no borrow).
- resp_ovf  output  1  signed overflow.
- resp_id  output  1  requester that issued this result.

Behaviour:
- Reset (rst=1 at an edge):
  - state=IDLE; rr pointer favours req0.
  - resp_valid=0, resp_sum=0, resp_cout=0, resp_ovf=0, resp_id=0; all internal operand and carry registers cleared.
  - Reset mid-operation discards the operation and emits no response.
- States:
  - IDLE -> LO on accept.
  - LO -> HI unconditionally.
  - HI -> RESP unconditionally.
  - RESP -> IDLE when resp_ready=1.
- Arbitration (IDLE only), combinational:
  - Only one valid: grant it.
  - Both valid: grant the requester the rr pointer favours.
  - reqN_ready=1 only for the granted requester while in IDLE; never in other states.
- Accept edge (reqN_valid & reqN_ready):
  - Register a, b^{64{sub}}, sub and id.
  - Pointer moves to favour the other requester.
- LO cycle: slice computes a[31:0] + b'[31:0] + sub. At the edge, register sum[31:0] and carry c32.
- HI cycle: slice computes a[63:32] + b'[63:32] + c32. At the edge, register:
  - sum[63:32]
  - resp_cout = slice cout
  - resp_ovf = (a[63] == b'[63]) & (sum[63] != a[63])
- Timing and throughput:
  - resp_valid is high in RESP: the cycle after the second edge following accept (latency 3 cycles accept-to-valid).
  - Minimum 4 cycles per operation; no overlap.
- Response hold: resp_* stable while resp_valid=1 and resp_ready=0. resp_valid drops the cycle after the handshake.
- Request rule: request inputs may change freely outside the accept cycle; operands are sampled only at accept.
- Wrap: 64-bit modular; e.g. FFFF_FFFF_FFFF_FFFF + 1 = 0 with cout=1.
- Exactly one rca_32 instance; its Cin mux selects sub (LO) or c32 (HI).

Decomposition:
- Package adder_share_pkg:
  - state enum {IDLE, LO, HI, RESP}
  - localparams W=64, HALF=32
  - requester id type.
- Sub-module: the existing rca_32, instantiated once.
- Optional sub-module rr_arb2: 2-way round-robin grant with pointer.

Test Plan:
- Basic add: req0 a=0x0000_0001_FFFF_FFFF, b=1, sub=0 -> resp_sum=0x0000_0002_0000_0000, cout=0, ovf=0, id=0; resp_valid 3 cycles after accept.
- Subtract and overflow: req1 a=5, b=7, sub=1 -> sum=0xFFFF_FFFF_FFFF_FFFE, cout=0, id=1. Then a=0x8000_0000_0000_0000, b=1, sub=1 -> sum=0x7FFF_FFFF_FFFF_FFFF, ovf=1, cout=1.
- Wrap: a=0xFFFF_FFFF_FFFF_FFFF, b=1, add -> sum=0, cout=1, ovf=0.
- Contention: both valid continuously for 4 ops -> grants in order 0,1,0,1; ready never high outside IDLE; ready never high for both at once.
- Backpressure: resp_ready=0 for 5 cycles in RESP -> outputs stable, no new accept; then resp_ready=1 -> IDLE the next cycle, next request accepted.
- Reset mid-op: rst=1 during HI -> next cycle all outputs 0, state IDLE, no response emitted; pointer favours req0.

Source files
------------

// File: rtl/adder_share_pkg.sv
// adder_share_pkg
//   Shared types and constants for the two-requester 64-bit add/subtract
//   controller that time-multiplexes a single 32-bit ripple-carry slice.
//   Contents: operand/slice widths, FSM state enum, requester id type.
package adder_share_pkg;

    localparam int W    = 64;     // operand width, two slice passes
    localparam int HALF = W / 2;  // slice width

    typedef enum logic [1:0] {
        IDLE,  // waiting for a request, arbitration active
        LO,    // slice works on bits [31:0]
        HI,    // slice works on bits [63:32]
        RESP   // result presented until the consumer takes it
    } state_t;

    typedef logic req_id_t;

    localparam req_id_t REQ0 = 1'b0;
    localparam req_id_t REQ1 = 1'b1;

endpackage

// File: rtl/rca_32.sv
// rca_32
//   32-bit ripple-carry adder slice.
//   Ports:
//     a_i, b_i  [31:0]  addends
//     cin_i             carry in
//     sum_o     [31:0]  a_i + b_i + cin_i, modulo 2^32
//     cout_o            carry out of bit 31
module rca_32 (
    input  logic [31:0] a_i,
    input  logic [31:0] b_i,
    input  logic        cin_i,
    output logic [31:0] sum_o,
    output logic        cout_o
);

    logic [32:0] carry;

    always_comb begin
        // NOTE: every combinational output gets a default before the loop so
        // no path leaves a variable unassigned and no latch is inferred.
        carry    = '0;
        sum_o    = '0;
        carry[0] = cin_i;
        for (int i = 0; i < 32; i++) begin
            sum_o[i]     = a_i[i] ^ b_i[i] ^ carry[i];
            carry[i + 1] = (a_i[i] & b_i[i]) | (carry[i] & (a_i[i] ^ b_i[i]));
        end
        cout_o = carry[32];
    end

endmodule

// File: rtl/rr_arb2.sv
// rr_arb2
//   Two-way round-robin arbiter. A lone request is granted directly; on a tie
//   the requester named by the pointer wins. The pointer moves to favour the
//   other requester whenever a grant is taken (advance_i).
//   Ports:
//     clk, rst        clock, synchronous active-high reset (pointer -> req0)
//     req0_i, req1_i  request lines
//     advance_i       the current grant was accepted this cycle
//     gnt_valid_o     some request is granted
//     gnt_id_o        which requester is granted
module rr_arb2
    import adder_share_pkg::*;
(
    input  logic    clk,
    input  logic    rst,
    input  logic    req0_i,
    input  logic    req1_i,
    input  logic    advance_i,
    output logic    gnt_valid_o,
    output req_id_t gnt_id_o
);

    req_id_t ptr_q;  // requester favoured on a tie

    always_comb begin
        gnt_valid_o = req0_i | req1_i;
        if (req0_i && req1_i) begin
            gnt_id_o = ptr_q;
        end else begin
            gnt_id_o = req1_i ? REQ1 : REQ0;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            ptr_q <= REQ0;
        end else if (advance_i) begin
            ptr_q <= ~gnt_id_o;
        end
    end

endmodule

// File: rtl/adder_share_ctrl.sv
// adder_share_ctrl
//   Two-requester 64-bit add/subtract unit built around one 32-bit ripple
//   slice used twice: low half in LO, high half in HI. Requests are
//   round-robin arbitrated in IDLE; the result is held in RESP until taken.
//   Accept-to-valid latency is 3 cycles; at least 4 cycles per operation.
//   Ports:
//     clk, rst                    clock, synchronous active-high reset
//     reqN_valid/ready            request handshake, requester N (0/1)
//     reqN_a, reqN_b  [63:0]      operands
//     reqN_sub                    1: a-b, 0: a+b
//     resp_valid/ready            response handshake
//     resp_sum        [63:0]      result
//     resp_cout                   carry out of bit 63 (sub: 1 = no borrow)
//     resp_ovf                    signed overflow
//     resp_id                     requester that issued the result
module adder_share_ctrl
    import adder_share_pkg::*;
(
    input  logic         clk,
    input  logic         rst,

    input  logic         req0_valid,
    output logic         req0_ready,
    input  logic [W-1:0] req0_a,
    input  logic [W-1:0] req0_b,
    input  logic         req0_sub,

    input  logic         req1_valid,
    output logic         req1_ready,
    input  logic [W-1:0] req1_a,
    input  logic [W-1:0] req1_b,
    input  logic         req1_sub,

    output logic         resp_valid,
    input  logic         resp_ready,
    output logic [W-1:0] resp_sum,
    output logic         resp_cout,
    output logic         resp_ovf,
    output logic         resp_id
);

    state_t        state_q;
    logic [W-1:0]  a_q;
    logic [W-1:0]  b_q;         // B already inverted for subtract
    logic          sub_q;
    req_id_t       id_q;
    logic          c32_q;       // carry from the low half into the high half
    logic [HALF-1:0] sum_lo_q;

    logic          resp_valid_q;
    logic [W-1:0]  resp_sum_q;
    logic          resp_cout_q;
    logic          resp_ovf_q;
    req_id_t       resp_id_q;

    // ---------------------------------------------------------------
    // Arbitration: only meaningful in IDLE, so requests are masked there.
    // ---------------------------------------------------------------
    logic    idle;
    logic    gnt_valid;
    req_id_t gnt_id;
    logic    accept;

    assign idle   = (state_q == IDLE);
    assign accept = idle & gnt_valid;

    rr_arb2 u_arb (
        .clk         (clk),
        .rst         (rst),
        .req0_i      (req0_valid & idle),
        .req1_i      (req1_valid & idle),
        .advance_i   (accept),
        .gnt_valid_o (gnt_valid),
        .gnt_id_o    (gnt_id)
    );

    assign req0_ready = accept & (gnt_id == REQ0);
    assign req1_ready = accept & (gnt_id == REQ1);

    logic [W-1:0] sel_a;
    logic [W-1:0] sel_b;
    logic         sel_sub;

    assign sel_a   = (gnt_id == REQ1) ? req1_a   : req0_a;
    assign sel_b   = (gnt_id == REQ1) ? req1_b   : req0_b;
    assign sel_sub = (gnt_id == REQ1) ? req1_sub : req0_sub;

    // ---------------------------------------------------------------
    // Shared slice: half select and carry-in mux (sub in LO, c32 in HI).
    // ---------------------------------------------------------------
    logic [HALF-1:0] slice_a;
    logic [HALF-1:0] slice_b;
    logic            slice_cin;
    logic [HALF-1:0] slice_sum;
    logic            slice_cout;

    always_comb begin
        slice_a   = a_q[HALF-1:0];
        slice_b   = b_q[HALF-1:0];
        slice_cin = sub_q;
        if (state_q == HI) begin
            slice_a   = a_q[W-1:HALF];
            slice_b   = b_q[W-1:HALF];
            slice_cin = c32_q;
        end
    end

    rca_32 u_slice (
        .a_i    (slice_a),
        .b_i    (slice_b),
        .cin_i  (slice_cin),
        .sum_o  (slice_sum),
        .cout_o (slice_cout)
    );

    // ---------------------------------------------------------------
    // Control FSM with registered datapath and response outputs.
    // ---------------------------------------------------------------
    // NOTE: state is updated with non-blocking assignments so every register
    // samples pre-edge values, independent of statement order.
    always_ff @(posedge clk) begin
        if (rst) begin
            // NOTE: operand and carry registers are cleared too, not just the
            // control state; the response registers drive outputs directly.
            state_q      <= IDLE;
            a_q          <= '0;
            b_q          <= '0;
            sub_q        <= 1'b0;
            id_q         <= REQ0;
            c32_q        <= 1'b0;
            sum_lo_q     <= '0;
            resp_valid_q <= 1'b0;
            resp_sum_q   <= '0;
            resp_cout_q  <= 1'b0;
            resp_ovf_q   <= 1'b0;
            resp_id_q    <= REQ0;
        end else begin
            case (state_q)
                IDLE: begin
                    if (accept) begin
                        a_q     <= sel_a;
                        b_q     <= sel_b ^ {W{sel_sub}};
                        sub_q   <= sel_sub;
                        id_q    <= gnt_id;
                        state_q <= LO;
                    end
                end
                LO: begin
                    sum_lo_q <= slice_sum;
                    c32_q    <= slice_cout;
                    state_q  <= HI;
                end
                HI: begin
                    resp_sum_q   <= {slice_sum, sum_lo_q};
                    resp_cout_q  <= slice_cout;
                    // Overflow: operands agree in sign, result does not.
                    resp_ovf_q   <= (a_q[W-1] == b_q[W-1]) &
                                    (slice_sum[HALF-1] != a_q[W-1]);
                    resp_id_q    <= id_q;
                    resp_valid_q <= 1'b1;
                    state_q      <= RESP;
                end
                RESP: begin
                    if (resp_ready) begin
                        resp_valid_q <= 1'b0;
                        state_q      <= IDLE;
                    end
                end
                default: state_q <= IDLE;
            endcase
        end
    end

    assign resp_valid = resp_valid_q;
    assign resp_sum   = resp_sum_q;
    assign resp_cout  = resp_cout_q;
    assign resp_ovf   = resp_ovf_q;
    assign resp_id    = resp_id_q;

endmodule

// File: tb/tb_adder_share_ctrl.sv
// tb_adder_share_ctrl
//   Self-checking bench for adder_share_ctrl: directed vector table, random
//   operations against an arithmetic reference model, and hand-written
//   sequences for contention, backpressure and reset in the middle of an op.
module tb_adder_share_ctrl;

    logic        clk = 1'b0;
    logic        rst;
    logic        req0_valid, req0_ready, req0_sub;
    logic [63:0] req0_a, req0_b;
    logic        req1_valid, req1_ready, req1_sub;
    logic [63:0] req1_a, req1_b;
    logic        resp_valid, resp_ready, resp_cout, resp_ovf, resp_id;
    logic [63:0] resp_sum;

    int checks   = 0;
    int failures = 0;

    always #5 clk = ~clk;

    adder_share_ctrl dut (
        .clk        (clk),
        .rst        (rst),
        .req0_valid (req0_valid),
        .req0_ready (req0_ready),
        .req0_a     (req0_a),
        .req0_b     (req0_b),
        .req0_sub   (req0_sub),
        .req1_valid (req1_valid),
        .req1_ready (req1_ready),
        .req1_a     (req1_a),
        .req1_b     (req1_b),
        .req1_sub   (req1_sub),
        .resp_valid (resp_valid),
        .resp_ready (resp_ready),
        .resp_sum   (resp_sum),
        .resp_cout  (resp_cout),
        .resp_ovf   (resp_ovf),
        .resp_id    (resp_id)
    );

    typedef struct {
        logic        id;
        logic [63:0] a;
        logic [63:0] b;
        logic        sub;
        logic [63:0] sum;
        logic        cout;
        logic        ovf;
    } vec_t;

    vec_t vecs[6];

    task automatic check(input string name, input logic [63:0] got, input logic [63:0] exp);
        checks++;
        if (got !== exp) begin
            failures++;
            $display("FAIL %s: got %h expected %h", name, got, exp);
        end
    endtask

    // Reference: plain 64-bit arithmetic. {ovf, cout, sum}
    function automatic logic [65:0] model(input logic [63:0] a, input logic [63:0] b, input logic sub);
        logic [64:0]        wide;
        logic signed [64:0] exact;
        logic               cout;
        if (sub) begin
            wide  = {1'b0, a} - {1'b0, b};
            cout  = (a >= b);  // no borrow
            exact = $signed({a[63], a}) - $signed({b[63], b});
        end else begin
            wide  = {1'b0, a} + {1'b0, b};
            cout  = wide[64];
            exact = $signed({a[63], a}) + $signed({b[63], b});
        end
        return {exact[64] != exact[63], cout, wide[63:0]};
    endfunction

    task automatic drive_req(input logic id, input logic [63:0] a, input logic [63:0] b, input logic sub);
        if (id) begin
            req1_valid = 1'b1; req1_a = a; req1_b = b; req1_sub = sub;
        end else begin
            req0_valid = 1'b1; req0_a = a; req0_b = b; req0_sub = sub;
        end
    endtask

    // Present a request and return just after its accept edge.
    task automatic issue(input logic id, input logic [63:0] a, input logic [63:0] b,
                         input logic sub, output bit ok);
        int n;
        @(negedge clk);
        drive_req(id, a, b, sub);
        #1;
        n = 0;
        while (!(id ? req1_ready : req0_ready) && n < 20) begin
            @(negedge clk);
            #1;
            n++;
        end
        ok = (n < 20);
        if (!ok) begin
            check("accept_timeout", 64'd0, 64'd1);
            req0_valid = 1'b0;
            req1_valid = 1'b0;
        end else begin
            @(posedge clk);
        end
    endtask

    // Count cycles from accept until resp_valid; scramble request inputs
    // after accept so late changes would corrupt a design that re-samples.
    task automatic wait_resp(output int lat);
        lat = 0;
        do begin
            @(negedge clk);
            lat++;
            if (lat == 1) begin
                req0_valid = 1'b0; req1_valid = 1'b0;
                req0_a = ~req0_a; req0_b = ~req0_b; req0_sub = ~req0_sub;
                req1_a = ~req1_a; req1_b = ~req1_b; req1_sub = ~req1_sub;
            end
        end while (!resp_valid && lat < 20);
        if (!resp_valid) check("resp_timeout", 64'd0, 64'd1);
    endtask

    task automatic finish_resp();
        resp_ready = 1'b1;
        @(posedge clk);
        @(negedge clk);
        resp_ready = 1'b0;
        check("valid_drop", {63'b0, resp_valid}, 64'd0);
    endtask

    task automatic run_op(input logic id, input logic [63:0] a, input logic [63:0] b,
                          input logic sub, input int stall,
                          output logic [63:0] sum, output logic cout, output logic ovf,
                          output logic rid, output int lat);
        bit ok;
        bit stable;
        sum = '0; cout = 1'b0; ovf = 1'b0; rid = 1'b0; lat = -1;
        issue(id, a, b, sub, ok);
        if (ok) begin
            wait_resp(lat);
            sum = resp_sum; cout = resp_cout; ovf = resp_ovf; rid = resp_id;
            stable = 1'b1;
            for (int k = 0; k < stall; k++) begin
                @(negedge clk);
                if ({resp_valid, resp_sum, resp_cout, resp_ovf, resp_id} !==
                    {1'b1, sum, cout, ovf, rid}) stable = 1'b0;
            end
            if (stall > 0) check("hold_stable", {63'b0, stable}, 64'd1);
            finish_resp();
        end
    endtask

    task automatic check_result(input string tag, input logic [63:0] sum, input logic cout,
                                input logic ovf, input logic rid, input int lat,
                                input logic [63:0] e_sum, input logic e_cout,
                                input logic e_ovf, input logic e_id);
        check({tag, "_sum"},  sum, e_sum);
        check({tag, "_cout"}, {63'b0, cout}, {63'b0, e_cout});
        check({tag, "_ovf"},  {63'b0, ovf},  {63'b0, e_ovf});
        check({tag, "_id"},   {63'b0, rid},  {63'b0, e_id});
        check({tag, "_lat"},  64'(lat), 64'd3);
    endtask

    initial begin
        #500000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        logic [63:0] sum, a, b, a2, b2;
        logic        cout, ovf, rid, sub, id;
        logic [65:0] exp;
        int          lat, stall, kind;
        bit          ok, stable, no_ready;

        vecs[0] = '{1'b0, 64'h0000_0001_FFFF_FFFF, 64'd1, 1'b0, 64'h0000_0002_0000_0000, 1'b0, 1'b0};
        vecs[1] = '{1'b1, 64'd5, 64'd7, 1'b1, 64'hFFFF_FFFF_FFFF_FFFE, 1'b0, 1'b0};
        vecs[2] = '{1'b0, 64'h8000_0000_0000_0000, 64'd1, 1'b1, 64'h7FFF_FFFF_FFFF_FFFF, 1'b1, 1'b1};
        vecs[3] = '{1'b1, 64'hFFFF_FFFF_FFFF_FFFF, 64'd1, 1'b0, 64'd0, 1'b1, 1'b0};
        vecs[4] = '{1'b0, 64'h7FFF_FFFF_FFFF_FFFF, 64'd1, 1'b0, 64'h8000_0000_0000_0000, 1'b0, 1'b1};
        vecs[5] = '{1'b1, 64'd0, 64'd0, 1'b1, 64'd0, 1'b1, 1'b0};

        rst = 1'b1;
        req0_valid = 1'b0; req0_a = '0; req0_b = '0; req0_sub = 1'b0;
        req1_valid = 1'b0; req1_a = '0; req1_b = '0; req1_sub = 1'b0;
        resp_ready = 1'b0;
        repeat (2) @(posedge clk);
        @(negedge clk);
        rst = 1'b0;

        // Reset state
        check("rst_valid", {63'b0, resp_valid}, 64'd0);
        check("rst_sum",   resp_sum, 64'd0);
        check("rst_cout",  {63'b0, resp_cout}, 64'd0);
        check("rst_ovf",   {63'b0, resp_ovf}, 64'd0);
        check("rst_id",    {63'b0, resp_id}, 64'd0);

        // Directed vector table
        for (int i = 0; i < 6; i++) begin
            run_op(vecs[i].id, vecs[i].a, vecs[i].b, vecs[i].sub, 0, sum, cout, ovf, rid, lat);
            check_result($sformatf("vec%0d", i), sum, cout, ovf, rid, lat,
                         vecs[i].sum, vecs[i].cout, vecs[i].ovf, vecs[i].id);
        end

        // Contention: both requesters valid continuously for 4 operations
        begin
            logic [63:0] ca[2];
            logic [63:0] cb[2];
            logic        cs[2];
            int          exp_g[4];
            int          grants[$];
            int          gaps[$];
            int          last_acc;
            int          nresp;
            int          bad;
            logic [65:0] e;

            ca[0] = 64'h1234_5678_9ABC_DEF0; cb[0] = 64'h0FED_CBA9_8765_4321; cs[0] = 1'b0;
            ca[1] = 64'h0000_0000_0000_0003; cb[1] = 64'h0000_0000_0000_0009; cs[1] = 1'b1;
            exp_g = '{0, 1, 0, 1};
            last_acc = -1; nresp = 0; bad = 0;

            @(negedge clk); rst = 1'b1;
            @(negedge clk); rst = 1'b0;
            resp_ready = 1'b1;
            drive_req(1'b0, ca[0], cb[0], cs[0]);
            drive_req(1'b1, ca[1], cb[1], cs[1]);
            for (int c = 0; c < 60 && nresp < 4; c++) begin
                if (c > 0) @(negedge clk);
                if (grants.size() == 4) begin
                    req0_valid = 1'b0;
                    req1_valid = 1'b0;
                end
                #1;
                if (req0_ready && req1_ready) bad++;
                if ((req0_ready || req1_ready) && resp_valid) bad++;
                if (req0_ready || req1_ready) begin
                    grants.push_back(req1_ready ? 1 : 0);
                    if (last_acc >= 0) gaps.push_back(c - last_acc);
                    last_acc = c;
                end
                if (resp_valid) begin
                    e = model(ca[exp_g[nresp]], cb[exp_g[nresp]], cs[exp_g[nresp]]);
                    check($sformatf("cont%0d_id", nresp), {63'b0, resp_id}, 64'(exp_g[nresp]));
                    check($sformatf("cont%0d_sum", nresp), resp_sum, e[63:0]);
                    nresp++;
                end
            end
            @(negedge clk);
            resp_ready = 1'b0;
            req0_valid = 1'b0;
            req1_valid = 1'b0;
            check("cont_nresp", 64'(nresp), 64'd4);
            check("cont_ngrants", 64'(grants.size()), 64'd4);
            for (int g = 0; g < grants.size() && g < 4; g++)
                check($sformatf("cont_grant%0d", g), 64'(grants[g]), 64'(exp_g[g]));
            for (int g = 0; g < gaps.size(); g++)
                check($sformatf("cont_gap%0d", g), 64'(gaps[g]), 64'd4);
            check("cont_ready_rules", 64'(bad), 64'd0);
        end

        // Backpressure: hold RESP for 5 cycles with a new request pending
        a  = 64'hDEAD_BEEF_0000_0001; b  = 64'h0000_0000_FFFF_FFFF;
        a2 = 64'h0000_0000_0000_0010; b2 = 64'h0000_0000_0000_0020;
        issue(1'b1, a, b, 1'b0, ok);
        if (ok) begin
            wait_resp(lat);
            sum = resp_sum; cout = resp_cout; ovf = resp_ovf; rid = resp_id;
            exp = model(a, b, 1'b0);
            check_result("bp", sum, cout, ovf, rid, lat, exp[63:0], exp[64], exp[65], 1'b1);
            drive_req(1'b0, a2, b2, 1'b1);
            stable = 1'b1; no_ready = 1'b1;
            for (int k = 0; k < 5; k++) begin
                if (k > 0) @(negedge clk);
                #1;
                if ({resp_valid, resp_sum, resp_cout, resp_ovf, resp_id} !==
                    {1'b1, sum, cout, ovf, rid}) stable = 1'b0;
                if (req0_ready || req1_ready) no_ready = 1'b0;
            end
            check("bp_stable", {63'b0, stable}, 64'd1);
            check("bp_no_accept", {63'b0, no_ready}, 64'd1);
            resp_ready = 1'b1;
            @(posedge clk);
            @(negedge clk);
            resp_ready = 1'b0;
            #1;
            check("bp_valid_drop", {63'b0, resp_valid}, 64'd0);
            check("bp_next_ready", {63'b0, req0_ready}, 64'd1);
            @(posedge clk);
            wait_resp(lat);
            exp = model(a2, b2, 1'b1);
            check_result("bp_next", resp_sum, resp_cout, resp_ovf, resp_id, lat,
                         exp[63:0], exp[64], exp[65], 1'b0);
            finish_resp();
        end

        // Reset during HI: discard the op, pointer back to req0
        issue(1'b1, 64'h1111_2222_3333_4444, 64'h5555_6666_7777_8888, 1'b0, ok);
        @(negedge clk);  // LO
        req1_valid = 1'b0;
        @(negedge clk);  // HI
        rst = 1'b1;
        @(negedge clk);
        rst = 1'b0;
        check("mid_rst_valid", {63'b0, resp_valid}, 64'd0);
        check("mid_rst_sum",   resp_sum, 64'd0);
        check("mid_rst_cout",  {63'b0, resp_cout}, 64'd0);
        check("mid_rst_ovf",   {63'b0, resp_ovf}, 64'd0);
        check("mid_rst_id",    {63'b0, resp_id}, 64'd0);
        a = 64'h0000_0000_0000_00FF; b = 64'h0000_0000_0000_0001;
        drive_req(1'b0, a, b, 1'b0);
        drive_req(1'b1, 64'd9, 64'd9, 1'b1);
        #1;
        check("mid_rst_ready0", {63'b0, req0_ready}, 64'd1);
        check("mid_rst_ready1", {63'b0, req1_ready}, 64'd0);
        @(posedge clk);
        wait_resp(lat);
        exp = model(a, b, 1'b0);
        check_result("mid_rst_next", resp_sum, resp_cout, resp_ovf, resp_id, lat,
                     exp[63:0], exp[64], exp[65], 1'b0);
        finish_resp();

        // Random operations against the reference model
        for (int i = 0; i < 40; i++) begin
            id    = 1'($urandom_range(0, 1));
            sub   = 1'($urandom_range(0, 1));
            stall = $urandom_range(0, 3);
            kind  = $urandom_range(0, 3);
            a     = {$urandom, $urandom};
            b     = {$urandom, $urandom};
            if (kind == 0) b = sub ? a : ~a;
            if (kind == 1) a = {32'h0000_0000, $urandom} | 64'h0000_0000_FFFF_0000;
            run_op(id, a, b, sub, stall, sum, cout, ovf, rid, lat);
            exp = model(a, b, sub);
            check_result($sformatf("rnd%0d", i), sum, cout, ovf, rid, lat,
                         exp[63:0], exp[64], exp[65], id);
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
